core_acc: RTL and testbench

CORE_ACC -- requirements
Module: core_acc

---
 rtl/core_acc_if.sv | 15 +
 rtl/core_acc.sv | 113 +++++++++++
 tb/tb_core_acc.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_acc_if.sv
// Beat/result bundle between a product source and the group accumulator.
// The master drives product beats; the slave returns registered group sums.
interface core_acc_if #(
  parameter int IDATA_BIT = 16,
  parameter int ODATA_BIT = 32
) ();
  logic signed [IDATA_BIT-1:0] idata;
  logic                        idata_valid;
  logic signed [ODATA_BIT-1:0] odata;
  logic                        odata_valid;
  logic                        odata_sat;

  modport master (output idata, idata_valid, input  odata, odata_valid, odata_sat);
  modport slave  (input  idata, idata_valid, output odata, odata_valid, odata_sat);
endinterface

// File: rtl/core_acc.sv
// Group accumulator: sums cfg_acc_num signed product beats and emits one
// saturated, registered group sum per group for the downstream quantizer.
//
// state | meaning
// IDLE  | no partial group held; next valid beat opens a group
// ACC   | partial group held; beats add until the latched target count
module core_acc #(
  parameter int IDATA_BIT = 16,
  parameter int ODATA_BIT = 32,
  parameter int CNT_BIT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_BIT-1:0] cfg_acc_num,
  input  logic               acc_clr,
  core_acc_if.slave          s_if,
  output logic               busy
);
  localparam int ACC_W = ODATA_BIT + CNT_BIT;
  localparam logic signed [ACC_W-1:0] ACC_OMAX =
    {{(CNT_BIT+1){1'b0}}, {(ODATA_BIT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_OMIN =
    {{(CNT_BIT+1){1'b1}}, {(ODATA_BIT-1){1'b0}}};
  localparam logic signed [ODATA_BIT-1:0] OMAX = {1'b0, {(ODATA_BIT-1){1'b1}}};
  localparam logic signed [ODATA_BIT-1:0] OMIN = {1'b1, {(ODATA_BIT-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     w_acc_nxt;
  logic signed [ACC_W-1:0]     w_idata_ext;
  logic [CNT_BIT-1:0]          r_cnt;
  logic [CNT_BIT-1:0]          w_cnt_nxt;
  logic [CNT_BIT-1:0]          r_target;
  logic [CNT_BIT-1:0]          w_target;
  logic                        w_last;
  logic                        w_sat;
  logic signed [ODATA_BIT-1:0] w_odata_clamp;
  logic signed [ODATA_BIT-1:0] r_odata;
  logic                        r_odata_valid;
  logic                        r_odata_sat;

  assign w_idata_ext = {{(ACC_W-IDATA_BIT){s_if.idata[IDATA_BIT-1]}}, s_if.idata};

  // Target is latched only on a group's first beat so mid-group cfg edits are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_target    = r_target;
    w_last      = 1'b0;
    if (acc_clr) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (s_if.idata_valid) begin
      case (r_state)
        IDLE: begin
          w_target  = (cfg_acc_num == '0) ? CNT_BIT'(1) : cfg_acc_num;
          w_acc_nxt = w_idata_ext;
          w_cnt_nxt = CNT_BIT'(1);
        end
        default: begin
          w_acc_nxt = r_acc + w_idata_ext;
          w_cnt_nxt = r_cnt + CNT_BIT'(1);
        end
      endcase
      w_last      = (w_cnt_nxt == w_target);
      w_state_nxt = w_last ? IDLE : ACC;
    end
  end

  always_comb begin
    w_sat         = 1'b0;
    w_odata_clamp = w_acc_nxt[ODATA_BIT-1:0];
    if (w_acc_nxt > ACC_OMAX) begin
      w_sat         = 1'b1;
      w_odata_clamp = OMAX;
    end else if (w_acc_nxt < ACC_OMIN) begin
      w_sat         = 1'b1;
      w_odata_clamp = OMIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_target      <= '0;
      r_odata       <= '0;
      r_odata_valid <= 1'b0;
      r_odata_sat   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_target      <= w_target;
      r_odata_valid <= w_last;
      r_odata_sat   <= w_last && w_sat;
      if (w_last) begin
        r_odata <= w_odata_clamp;
      end
    end
  end

  assign s_if.odata       = r_odata;
  assign s_if.odata_valid = r_odata_valid;
  assign s_if.odata_sat   = r_odata_sat;
  assign busy             = (r_state == ACC);
endmodule

// File: tb/tb_core_acc.sv
// Bench for core_acc: a 32-bit and a 16-bit output instance share stimulus and
// are compared against a group-sum reference model plus directed constants.
module tb_core_acc;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] drv_idata = '0;
  logic               drv_valid = 1'b0;
  logic [15:0]        drv_cfg = '0;
  logic               drv_clr = 1'b0;
  logic               busy_a;
  logic               busy_b;
  int                 errors = 0;
  int                 checks = 0;

  core_acc_if #(.IDATA_BIT(16), .ODATA_BIT(32)) ifa ();
  core_acc_if #(.IDATA_BIT(16), .ODATA_BIT(16)) ifb ();

  assign ifa.idata       = drv_idata;
  assign ifa.idata_valid = drv_valid;
  assign ifb.idata       = drv_idata;
  assign ifb.idata_valid = drv_valid;

  core_acc #(.IDATA_BIT(16), .ODATA_BIT(32), .CNT_BIT(16)) dut_a (
    .clk(clk), .rst(rst), .cfg_acc_num(drv_cfg), .acc_clr(drv_clr),
    .s_if(ifa), .busy(busy_a));
  core_acc #(.IDATA_BIT(16), .ODATA_BIT(16), .CNT_BIT(16)) dut_b (
    .clk(clk), .rst(rst), .cfg_acc_num(drv_cfg), .acc_clr(drv_clr),
    .s_if(ifb), .busy(busy_b));

  always #5 clk = ~clk;

  // Reference model: running sum and beat count of the open group.
  longint      m_sum = 0;
  int          m_n = 0;
  int          m_target = 1;
  logic        m_valid = 1'b0;
  logic        m_sat32 = 1'b0;
  logic        m_sat16 = 1'b0;
  logic        m_busy = 1'b0;
  logic [31:0] m_o32 = '0;
  logic [15:0] m_o16 = '0;

  function automatic longint clampw(input longint x, input int w, output bit sat);
    longint hi, lo;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    sat = (x > hi) || (x < lo);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  always @(posedge clk) begin : model
    longint s, c32, c16;
    int     n, t;
    bit     v, s32, s16;
    s = m_sum; n = m_n; t = m_target; v = 0; s32 = 0; s16 = 0;
    c32 = longint'(signed'(m_o32)); c16 = longint'(signed'(m_o16));
    if (rst) begin
      s = 0; n = 0; c32 = 0; c16 = 0;
    end else if (drv_clr) begin
      s = 0; n = 0;
    end else if (drv_valid) begin
      if (n == 0) begin
        t = (drv_cfg == 0) ? 1 : int'(drv_cfg);
        s = 0;
      end
      s = s + longint'(drv_idata);
      n = n + 1;
      if (n == t) begin
        v = 1;
        c32 = clampw(s, 32, s32);
        c16 = clampw(s, 16, s16);
        n = 0; s = 0;
      end
    end
    m_sum    <= s;
    m_n      <= n;
    m_target <= t;
    m_valid  <= v;
    m_sat32  <= s32;
    m_sat16  <= s16;
    m_o32    <= c32[31:0];
    m_o16    <= c16[15:0];
    m_busy   <= (n != 0);
  end

  function automatic logic [53:0] got_vec();
    return {ifa.odata_valid, ifa.odata_sat, ifb.odata_valid, ifb.odata_sat,
            busy_a, busy_b, ifa.odata, ifb.odata};
  endfunction

  function automatic logic [53:0] exp_vec();
    return {m_valid, m_sat32, m_valid, m_sat16, m_busy, m_busy, m_o32, m_o16};
  endfunction

  // Drive one cycle of inputs from a negedge and return on the following negedge.
  task automatic cycle(input bit v, input int d, input int cfg, input bit clr);
    drv_valid = v;
    drv_idata = 16'(d);
    drv_cfg   = 16'(cfg);
    drv_clr   = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 123, 1, 0);
      if (got_vec() !== 54'd0) begin
        errors++;
        $display("FAIL reset cyc%0d got=%h exp=0", i, got_vec());
      end
      checks++;
    end
    rst = 1'b0;
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_basic();
    int beats[4] = '{3, -1, 10, 5};
    for (int i = 0; i < 4; i++) begin
      cycle(1, beats[i], 4, 0);
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_model beat%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      checks++;
    end
    if (ifa.odata_valid !== 1'b1 || ifa.odata !== 32'sd17 || ifa.odata_sat !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum got v=%b d=%0d s=%b busy=%b exp v=1 d=17 s=0 busy=0",
               ifa.odata_valid, ifa.odata, ifa.odata_sat, busy_a);
    end
    checks++;
    cycle(0, 0, 4, 0);
    if (ifa.odata_valid !== 1'b0 || ifa.odata !== 32'sd17) begin
      errors++;
      $display("FAIL basic_hold got v=%b d=%0d exp v=0 d=17", ifa.odata_valid, ifa.odata);
    end
    checks++;
  endtask

  task automatic test_cfg_zero();
    int beats[2] = '{7, -2};
    for (int i = 0; i < 2; i++) begin
      cycle(1, beats[i], 0, 0);
      if (ifa.odata_valid !== 1'b1 || ifa.odata !== 32'(beats[i]) || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL cfg_zero beat%0d got v=%b d=%0d busy=%b exp v=1 d=%0d busy=0",
                 i, ifa.odata_valid, ifa.odata, busy_a, beats[i]);
      end
      checks++;
    end
    cycle(0, 0, 0, 0);
    if (got_vec() !== exp_vec() || ifa.odata_valid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_zero_end got=%h exp=%h", got_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_gap_cfg_change();
    int pulses = 0;
    cycle(1, 1, 3, 0); pulses += int'(ifa.odata_valid);
    cycle(1, 2, 3, 0); pulses += int'(ifa.odata_valid);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 8, 0);
      pulses += int'(ifa.odata_valid);
      if (busy_a !== 1'b1 || got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gap_hold cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      checks++;
    end
    cycle(1, 4, 8, 0);
    if (pulses !== 0 || ifa.odata_valid !== 1'b1 || ifa.odata !== 32'sd7 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL gap_sum got early=%0d v=%b d=%0d busy=%b exp early=0 v=1 d=7 busy=0",
               pulses, ifa.odata_valid, ifa.odata, busy_a);
    end
    checks++;
    cycle(0, 0, 8, 0);
  endtask

  task automatic test_saturation();
    cycle(1, 32767, 2, 0);
    cycle(1, 32767, 2, 0);
    if (ifb.odata !== 16'sd32767 || ifb.odata_sat !== 1'b1 || ifb.odata_valid !== 1'b1 ||
        ifa.odata !== 32'sd65534 || ifa.odata_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_pos got b=%0d bs=%b a=%0d as=%b exp b=32767 bs=1 a=65534 as=0",
               ifb.odata, ifb.odata_sat, ifa.odata, ifa.odata_sat);
    end
    checks++;
    cycle(1, -32768, 2, 0);
    if (ifb.odata_sat !== 1'b0 || ifb.odata_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_pulse got v=%b s=%b exp v=0 s=0", ifb.odata_valid, ifb.odata_sat);
    end
    checks++;
    cycle(1, -32768, 2, 0);
    if (ifb.odata !== -16'sd32768 || ifb.odata_sat !== 1'b1 ||
        ifa.odata !== -32'sd65536 || ifa.odata_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_neg got b=%0d bs=%b a=%0d as=%b exp b=-32768 bs=1 a=-65536 as=0",
               ifb.odata, ifb.odata_sat, ifa.odata, ifa.odata_sat);
    end
    checks++;
    cycle(0, 0, 2, 0);
  endtask

  task automatic test_clr();
    int pulses = 0;
    int beats[7] = '{5, 5, 9, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      cycle(1, beats[i], 4, (i == 2));
      pulses += int'(ifa.odata_valid);
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clr_model cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      checks++;
    end
    if (pulses !== 1 || ifa.odata_valid !== 1'b1 || ifa.odata !== 32'sd4) begin
      errors++;
      $display("FAIL clr_sum got pulses=%0d v=%b d=%0d exp pulses=1 v=1 d=4",
               pulses, ifa.odata_valid, ifa.odata);
    end
    checks++;
    cycle(0, 0, 4, 0);
  endtask

  task automatic test_rst_mid();
    cycle(1, 3, 4, 0);
    cycle(1, 3, 4, 0);
    rst = 1'b1;
    cycle(1, 9, 4, 1);
    if (got_vec() !== 54'd0) begin
      errors++;
      $display("FAIL rst_mid_zero got=%h exp=0", got_vec());
    end
    checks++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1, 2, 4, 0);
    if (ifa.odata_valid !== 1'b1 || ifa.odata !== 32'sd8 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_sum got v=%b d=%0d busy=%b exp v=1 d=8 busy=0",
               ifa.odata_valid, ifa.odata, busy_a);
    end
    checks++;
    cycle(0, 0, 4, 0);
    if (busy_a !== 1'b0 || ifa.odata_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after got busy=%b v=%b exp busy=0 v=0", busy_a, ifa.odata_valid);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, $urandom_range(0, 2000) - 1000, 2, 0);
      pulses += int'(ifa.odata_valid);
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_model cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      checks++;
    end
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d exp=3", pulses);
    end
    checks++;
    cycle(0, 0, 2, 0);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       d = 32767;
        1:       d = -32768;
        default: d = int'($urandom_range(0, 65535)) - 32768;
      endcase
      rst = ($urandom_range(0, 99) == 0);
      cycle(($urandom_range(0, 9) < 7), d, $urandom_range(0, 5),
            ($urandom_range(0, 29) == 0));
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      checks++;
    end
    rst = 1'b0;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_cfg_zero();
    test_gap_cfg_change();
    test_saturation();
    test_clr();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
